// File: rtl/rime_pkg.sv
// Shared definitions for the bus controller: FSM state encoding, transfer
// direction codes and the burst-length field width.
package rime_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DRIVE = 3'd2,
    ST_WRITE = 3'd3,
    ST_TURN  = 3'd4
  } state_e;

  localparam logic DIR_STORE = 1'b0;
  localparam logic DIR_LOAD  = 1'b1;

  localparam int unsigned LEN_W = 4;

endpackage

// File: rtl/addr_ctr.sv
// RAM address register: loads the burst base address and steps by one per
// word, wrapping naturally at 2^ADDR_WIDTH.
module addr_ctr #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] load_val,
  output logic [ADDR_WIDTH-1:0] q
);

  logic [ADDR_WIDTH-1:0] r_q;

  // Address register; load wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= load_val;
    end else if (inc) begin
      r_q <= r_q + ADDR_WIDTH'(1);
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/bus_ctrl_chk.sv
// Bus-safety properties for bus_ctrl: output-enables are mutually exclusive
// and a write-enable only fires while the opposite side drives the bus.
module bus_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic oe_reg,
  input logic we_reg,
  input logic oe_ram,
  input logic we_ram
);

  a_oe_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(oe_reg && oe_ram));

  a_we_ram_has_src: assert property (@(posedge clk) disable iff (rst)
    we_ram |-> oe_reg);

  a_we_reg_has_src: assert property (@(posedge clk) disable iff (rst)
    we_reg |-> oe_ram);

endmodule

// File: rtl/bus_ctrl.sv
// Register <-> RAM burst transfer controller. Each word runs through
// ADDR, DRIVE, WRITE and TURN, one cycle each, with registered strobes.
module bus_ctrl
  import rime_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dir,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_W-1:0]      len,
  output logic                  ready,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] addr_bus,
  output logic                  oe_reg,
  output logic                  we_reg,
  output logic                  oe_ram,
  output logic                  we_ram
);

  if (WIDTH < 1) begin : g_width_chk
    $error("bus_ctrl: WIDTH must be at least 1");
  end

  state_e           r_state;
  logic             r_dir;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_done;
  logic             r_oe_reg;
  logic             r_we_reg;
  logic             r_oe_ram;
  logic             r_we_ram;

  logic w_last;
  logic w_load;
  logic w_inc;

  assign w_last = (r_cnt == r_len);
  assign w_load = (r_state == ST_IDLE) && start;
  assign w_inc  = (r_state == ST_TURN) && !w_last;

  addr_ctr #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .inc      (w_inc),
    .load_val (base_addr),
    .q        (addr_bus)
  );

  // Sequencer; strobes are computed for the state being entered so they
  // come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_dir    <= DIR_STORE;
      r_len    <= '0;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_oe_reg <= 1'b0;
      r_we_reg <= 1'b0;
      r_oe_ram <= 1'b0;
      r_we_ram <= 1'b0;
    end else begin
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_oe_reg <= 1'b0;
      r_we_reg <= 1'b0;
      r_oe_ram <= 1'b0;
      r_we_ram <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_dir   <= dir;
            r_len   <= len;
            r_cnt   <= '0;
            r_state <= ST_ADDR;
          end else begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          r_oe_reg <= (r_dir == DIR_STORE);
          r_oe_ram <= (r_dir == DIR_LOAD);
          r_state  <= ST_DRIVE;
        end
        ST_DRIVE: begin
          r_oe_reg <= (r_dir == DIR_STORE);
          r_oe_ram <= (r_dir == DIR_LOAD);
          r_we_ram <= (r_dir == DIR_STORE);
          r_we_reg <= (r_dir == DIR_LOAD);
          r_state  <= ST_WRITE;
        end
        ST_WRITE: begin
          r_done  <= w_last;
          r_state <= ST_TURN;
        end
        ST_TURN: begin
          if (w_last) begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt   <= r_cnt + LEN_W'(1);
            r_state <= ST_ADDR;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready  = r_ready;
  assign done   = r_done;
  assign oe_reg = r_oe_reg;
  assign we_reg = r_we_reg;
  assign oe_ram = r_oe_ram;
  assign we_ram = r_we_ram;

endmodule

// File: tb/tb_bus_ctrl.sv
// Scoreboard bench for bus_ctrl: a transaction-level model expands each
// accepted burst into per-cycle expected bus activity; a monitor compares.
module tb_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dir;
  logic [7:0] base_addr;
  logic [3:0] len;
  logic       ready;
  logic       done;
  logic [7:0] addr_bus;
  logic       oe_reg;
  logic       we_reg;
  logic       oe_ram;
  logic       we_ram;

  always #5 clk = ~clk;

  bus_ctrl #(.WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dir       (dir),
    .base_addr (base_addr),
    .len       (len),
    .ready     (ready),
    .done      (done),
    .addr_bus  (addr_bus),
    .oe_reg    (oe_reg),
    .we_reg    (we_reg),
    .oe_ram    (oe_ram),
    .we_ram    (we_ram)
  );

  bus_ctrl_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .oe_reg (oe_reg),
    .we_reg (we_reg),
    .oe_ram (oe_ram),
    .we_ram (we_ram)
  );

  // strb = {done, oe_reg, oe_ram, we_reg, we_ram}
  typedef struct {
    int         c;
    logic [7:0] addr;
    logic [4:0] strb;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         busy_end = -1;
  logic [7:0] idle_addr = 8'h00;
  int         last_accept = 0;
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: called just after a falling edge; describes what the next rising
  // edge will do to the bus.
  task automatic drive(input logic r, input logic s, input logic d,
                       input logic [7:0] b, input logic [3:0] l);
    int c1;
    int words;
    exp_t e;
    c1 = cyc + 1;
    rst = r; start = s; dir = d; base_addr = b; len = l;
    if (r) begin
      q.delete();
      busy_end  = c1 - 1;
      idle_addr = 8'h00;
    end else if (s && cyc >= busy_end + 1) begin
      words = int'(l) + 1;
      last_accept = c1;
      for (int k = 0; k < 4 * words; k++) begin
        e.c    = c1 + k;
        e.addr = b + 8'(k / 4);
        case (k % 4)
          0: e.strb = 5'b00000;
          1: e.strb = d ? 5'b00100 : 5'b01000;
          2: e.strb = d ? 5'b00110 : 5'b01001;
          default: e.strb = (k / 4 == words - 1) ? 5'b10000 : 5'b00000;
        endcase
        q.push_back(e);
      end
      busy_end  = c1 + 4 * words - 1;
      idle_addr = b + 8'(l);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic d, input logic [7:0] b, input logic [3:0] l);
    int i;
    i = 0;
    while (cyc < busy_end + 1 && i < 200) begin
      step();
      i++;
    end
    if (i >= 200) begin
      checks++;
      failures++;
      $display("FAIL idle_wait: still busy, cyc=%0d required idle after %0d", cyc, busy_end);
    end
    drive(1'b0, 1'b1, d, b, l);
    step();
    drive(1'b0, 1'b0, 1'($urandom), 8'($urandom), 4'($urandom));
  endtask

  exp_t       m_e;
  logic [7:0] m_addr;
  logic [4:0] m_strb;
  logic       m_rdy;

  // Monitor: one comparison per cycle against the scoreboard head or idle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].c == cyc) begin
        m_e    = q.pop_front();
        m_addr = m_e.addr;
        m_strb = m_e.strb;
        m_rdy  = 1'b0;
      end else begin
        m_addr = idle_addr;
        m_strb = 5'b00000;
        m_rdy  = (cyc >= busy_end + 1);
      end
      checks++;
      if ({addr_bus, done, oe_reg, oe_ram, we_reg, we_ram, ready} !== {m_addr, m_strb, m_rdy}) begin
        failures++;
        $display("FAIL bus_cycle c=%0d: got addr=%h d/oeg/oem/weg/wem=%b rdy=%b, required addr=%h %b rdy=%b",
                 cyc, addr_bus, {done, oe_reg, oe_ram, we_reg, we_ram}, ready,
                 m_addr, m_strb, m_rdy);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; dir = 1'b0; base_addr = 8'h00; len = 4'h0;
    @(negedge clk);
    mon_en = 1'b1;
    #1;
    drive(1'b1, 1'b1, 1'b1, 8'hAA, 4'hF);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    step();

    issue(1'b0, 8'h10, 4'd0);
    issue(1'b1, 8'h20, 4'd2);
    issue(1'b0, 8'hFE, 4'd3);

    issue(1'b0, 8'h40, 4'd2);
    repeat (4) step();
    drive(1'b0, 1'b1, 1'b1, 8'h55, 4'd9);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'd0);

    issue(1'b0, 8'h30, 4'd3);
    while (cyc < last_accept + 6) step();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
    step();

    issue(1'b1, 8'h77, 4'd1);
    step();
    drive(1'b1, 1'b1, 1'b0, 8'h99, 4'd5);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
    step();

    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom), 8'($urandom), 4'($urandom));
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'd0);

    for (int i = 0; i < 100 && cyc < busy_end + 2; i++) step();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected bus cycles left, required 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
